// File: rtl/rgb_result_driver.sv
// Debounces an asynchronous one-hot comparator result and drives an RGB LED:
// a short blink on each new result, then steady PWM brightness; white on invalid input.
module rgb_result_driver #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned FLASH_HALF    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [0:2]          rgb_in,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [0:2]          led,
    output logic [0:2]          result,
    output logic                changed,
    output logic                error
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam int unsigned TMR_W = $clog2(FLASH_HALF + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FLASH_HALF - 1);

    typedef enum logic [1:0] {IDLE, FLASH, SHOW, ERR} state_e;

    logic [0:2]          s1_q, s2_q;
    logic [0:2]          cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [0:2]          result_q, result_d;
    logic                changed_q, changed_d;
    logic                error_q, error_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                phase_q, phase_d;
    logic [1:0]          halves_q, halves_d;
    state_e              state_q, state_d;
    logic [0:2]          led_q, led_d;

    logic stable, cand_multi, commit, err_rise, err_fall, pwm_on;

    function automatic logic multi_hot(input logic [0:2] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    assign stable     = (cnt_q == CNT_MAX);
    assign cand_multi = multi_hot(cand_q);
    assign commit     = stable && !cand_multi && (cand_q != result_q);
    assign err_rise   = error_d && !error_q;
    assign err_fall   = !error_d && error_q;
    assign pwm_on     = (pwm_q < brightness);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        changed_d = 1'b0;
        error_d   = error_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (!stable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // A stable valid candidate clears the error whether or not it commits.
        if (stable) error_d = cand_multi;
        if (commit) begin
            result_d  = cand_q;
            changed_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        phase_d  = phase_q;
        halves_d = halves_q;
        if (state_q == FLASH) begin
            if (tmr_q == TMR_LAST) begin
                tmr_d    = '0;
                phase_d  = !phase_q;
                halves_d = halves_q + 2'd1;
                if (halves_q == 2'd3) state_d = SHOW;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
        // Commit outranks error transitions; a commit always clears the error anyway.
        if (commit) begin
            if (cand_q == 3'b000) begin
                state_d = IDLE;
            end else begin
                state_d  = FLASH;
                tmr_d    = '0;
                phase_d  = 1'b1;
                halves_d = '0;
            end
        end else if (err_rise) begin
            state_d = ERR;
        end else if (err_fall) begin
            state_d = (result_q != 3'b000) ? SHOW : IDLE;
        end
    end

    always_comb begin
        led_d = 3'b000;
        case (state_q)
            FLASH:   led_d = phase_q ? result_q : 3'b000;
            SHOW:    led_d = result_q & {3{pwm_on}};
            ERR:     led_d = {3{pwm_on}};
            default: led_d = 3'b000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            changed_q <= 1'b0;
            error_q   <= 1'b0;
            pwm_q     <= '0;
            tmr_q     <= '0;
            phase_q   <= 1'b0;
            halves_q  <= '0;
            state_q   <= IDLE;
            led_q     <= '0;
        end else begin
            s1_q      <= rgb_in;
            s2_q      <= s1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            changed_q <= changed_d;
            error_q   <= error_d;
            pwm_q     <= pwm_q + PWM_BITS'(1);
            tmr_q     <= tmr_d;
            phase_q   <= phase_d;
            halves_q  <= halves_d;
            state_q   <= state_d;
            led_q     <= led_d;
        end
    end

    assign led     = led_q;
    assign result  = result_q;
    assign changed = changed_q;
    assign error   = error_q;

endmodule

// File: tb/tb_rgb_result_driver.sv
// Directed scoreboard bench for rgb_result_driver with STABLE_CYCLES=4, PWM_BITS=4, FLASH_HALF=2.
module tb_rgb_result_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:2] rgb_in;
    logic [3:0] brightness;
    logic [0:2] led;
    logic [0:2] result;
    logic       changed;
    logic       error;

    int tests_run = 0;
    int failed    = 0;

    typedef struct packed {
        logic [0:2] led;
        logic [0:2] result;
        logic       changed;
        logic       error;
        logic       chk_led;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];

    rgb_result_driver #(
        .STABLE_CYCLES(4),
        .PWM_BITS     (4),
        .FLASH_HALF   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rgb_in    (rgb_in),
        .brightness(brightness),
        .led       (led),
        .result    (result),
        .changed   (changed),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [0:2] l, input logic [0:2] r,
                        input logic c, input logic e, input logic cl);
        exp_t x;
        x.led = l; x.result = r; x.changed = c; x.error = e; x.chk_led = cl;
        sb.push_back(x);
        tag_q.push_back(tag);
    endtask

    task automatic push_hold(input string tag, input int n, input logic [0:2] r,
                             input logic e, input logic [0:2] l, input logic cl);
        for (int i = 0; i < n; i++) push(tag, l, r, 1'b0, e, cl);
    endtask

    // Blink pattern seen on led for the 8 edges following a commit.
    task automatic push_blink(input string tag, input logic [0:2] r);
        for (int i = 0; i < 8; i++) push(tag, ((i % 4) < 2) ? r : 3'b000, r, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_sb();
        exp_t  e;
        string t;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            t = tag_q.pop_front();
            check({t, ".result"},  32'(result),  32'(e.result));
            check({t, ".changed"}, 32'(changed), 32'(e.changed));
            check({t, ".error"},   32'(error),   32'(e.error));
            if (e.chk_led) check({t, ".led"}, 32'(led), 32'(e.led));
        end
    endtask

    // Counts led==on_val over one full PWM period at a fixed brightness.
    task automatic pwm_window(input string tag, input logic [3:0] b, input logic [0:2] on_val,
                              input int exp_on);
        int on_cnt;
        int bad;
        on_cnt = 0;
        bad    = 0;
        brightness = b;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (led === on_val) on_cnt++;
            else if (led !== 3'b000) bad++;
        end
        check({tag, ".on_count"}, 32'(on_cnt), 32'(exp_on));
        check({tag, ".bad_led"},  32'(bad),    32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        rgb_in     = 3'b000;
        brightness = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.led",     32'(led),     32'd0);
        check("reset.result",  32'(result),  32'd0);
        check("reset.changed", 32'(changed), 32'd0);
        check("reset.error",   32'(error),   32'd0);

        // First commit of 010 lands on edge 7, then the blink, then PWM at zero duty.
        rst    = 1'b0;
        rgb_in = 3'b010;
        push_hold("first_wait", 6, 3'b000, 1'b0, 3'b000, 1'b1);
        push("first_commit", 3'b000, 3'b010, 1'b1, 1'b0, 1'b1);
        push_blink("first_blink", 3'b010);
        push("first_show", 3'b000, 3'b010, 1'b0, 1'b0, 1'b1);
        run_sb();

        // Switch to 100 from SHOW, then PWM duty windows.
        rgb_in = 3'b100;
        push_hold("to100_wait", 6, 3'b010, 1'b0, 3'b000, 1'b1);
        push("to100_commit", 3'b000, 3'b100, 1'b1, 1'b0, 1'b1);
        push_blink("to100_blink", 3'b100);
        push("to100_show", 3'b000, 3'b100, 1'b0, 1'b0, 1'b1);
        run_sb();
        pwm_window("pwm_b4",  4'd4,  3'b100, 4);
        pwm_window("pwm_b0",  4'd0,  3'b100, 0);
        pwm_window("pwm_b15", 4'd15, 3'b100, 15);

        // Bouncing input never holds long enough to commit.
        for (int r = 0; r < 4; r++) begin
            rgb_in = 3'b001;
            push_hold("bounce", 3, 3'b100, 1'b0, 3'b000, 1'b0);
            run_sb();
            rgb_in = 3'b100;
            push_hold("bounce", 3, 3'b100, 1'b0, 3'b000, 1'b0);
            run_sb();
        end
        push_hold("bounce_settle", 8, 3'b100, 1'b0, 3'b000, 1'b0);
        run_sb();

        // Two bits set: error, result held, white at set duty.
        brightness = 4'd4;
        rgb_in     = 3'b110;
        push_hold("inv_wait", 6, 3'b100, 1'b0, 3'b000, 1'b0);
        push("inv_err", 3'b000, 3'b100, 1'b0, 1'b1, 1'b0);
        run_sb();
        pwm_window("err_white", 4'd4, 3'b111, 4);

        // Valid input clears the error with a commit and a fresh blink.
        rgb_in = 3'b001;
        push_hold("recover_wait", 6, 3'b100, 1'b1, 3'b000, 1'b0);
        push("recover_commit", 3'b000, 3'b001, 1'b1, 1'b0, 1'b0);
        run_sb();

        // New value mid-blink restarts the blink with phase on.
        rgb_in = 3'b100;
        push("restart_pre", 3'b001, 3'b001, 1'b0, 1'b0, 1'b1);
        push("restart_pre", 3'b001, 3'b001, 1'b0, 1'b0, 1'b1);
        push("restart_pre", 3'b000, 3'b001, 1'b0, 1'b0, 1'b1);
        push("restart_pre", 3'b000, 3'b001, 1'b0, 1'b0, 1'b1);
        push("restart_pre", 3'b001, 3'b001, 1'b0, 1'b0, 1'b1);
        push("restart_pre", 3'b001, 3'b001, 1'b0, 1'b0, 1'b1);
        push("restart_commit", 3'b000, 3'b100, 1'b1, 1'b0, 1'b1);
        push_blink("restart_blink", 3'b100);
        push("restart_show", 3'b000, 3'b100, 1'b0, 1'b0, 1'b0);
        run_sb();

        // Asynchronous reset in the middle of a blink.
        rgb_in = 3'b010;
        push_hold("pre_rst_wait", 6, 3'b100, 1'b0, 3'b000, 1'b0);
        push("pre_rst_commit", 3'b000, 3'b010, 1'b1, 1'b0, 1'b0);
        push("pre_rst_blink", 3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
        push("pre_rst_blink", 3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
        run_sb();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.led",     32'(led),     32'd0);
        check("async_rst.result",  32'(result),  32'd0);
        check("async_rst.error",   32'(error),   32'd0);
        check("async_rst.changed", 32'(changed), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full latency again after reset; then a commit of 000 mid-blink returns to IDLE.
        push_hold("post_rst_wait", 6, 3'b000, 1'b0, 3'b000, 1'b1);
        push("post_rst_commit", 3'b000, 3'b010, 1'b1, 1'b0, 1'b1);
        run_sb();
        rgb_in = 3'b000;
        push("clear_pre", 3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
        push("clear_pre", 3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
        push("clear_pre", 3'b000, 3'b010, 1'b0, 1'b0, 1'b1);
        push("clear_pre", 3'b000, 3'b010, 1'b0, 1'b0, 1'b1);
        push("clear_pre", 3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
        push("clear_pre", 3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
        push("clear_commit", 3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
        push_hold("clear_idle", 3, 3'b000, 1'b0, 3'b000, 1'b1);
        run_sb();

        // Error with no result, cleared by a stable 000 that matches result.
        rgb_in = 3'b111;
        push_hold("white_wait", 6, 3'b000, 1'b0, 3'b000, 1'b1);
        push("white_err", 3'b000, 3'b000, 1'b0, 1'b1, 1'b1);
        run_sb();
        rgb_in = 3'b000;
        push_hold("white_hold", 6, 3'b000, 1'b1, 3'b000, 1'b0);
        push("white_clear", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        push_hold("white_idle", 2, 3'b000, 1'b0, 3'b000, 1'b1);
        run_sb();

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
